spi_slave_obi_tx_fifo: RTL and testbench

- Synchronous ready/valid FIFO between the OBI master plug's read-data output (tx_data/tx_valid/tx_ready) and the SPI slave tx shift register.
- Decouples OBI read latency from the SPI bit clock so read words can be prefetched while the current word is shifted out.
- Supports a flush that discards stale prefetched words when the SPI transaction ends (cs deasserts).
- Single clock domain (OBI clock).

---
 rtl/spi_slave_obi_tx_fifo.sv | 73 +++++++
 tb/tb_spi_slave_obi_tx_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_obi_tx_fifo.sv
// Ready/valid word FIFO from the OBI read plug to the SPI tx shifter. The write-to-read latency is one cycle, with no bypass.
// ready_o is low when full or flushing and never depends on ready_i. flush_i empties the FIFO in one cycle.
module spi_slave_obi_tx_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  obi_aclk,
   input  logic                  obi_aresetn,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [CNT_WIDTH-1:0]  elements_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int                PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_WIDTH-1:0]  r_count;

   logic                  w_push;
   logic                  w_pop;

   assign full_o     = (r_count == FULL_CNT);
   assign empty_o    = (r_count == '0);
   assign elements_o = r_count;
   assign ready_o    = !full_o && !flush_i;
   assign valid_o    = !empty_o;
   assign data_o     = r_mem[r_rd_ptr];

   assign w_push = valid_i && ready_o;
   assign w_pop  = valid_o && ready_i;

   always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush_i) begin
         // Storage is left stale; only the bookkeeping is cleared.
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
            r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_obi_tx_fifo.sv
// Scoreboard bench: two instances (DEPTH 4 and DEPTH 3) share all inputs, and each instance has its own expected-word queue.
module tb_spi_slave_obi_tx_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        vld = 1'b0;
   logic        rdy = 1'b0;
   logic [31:0] din = '0;

   logic [31:0] d4_dat, d3_dat;
   logic        d4_vld, d4_rdy, d4_full, d4_empty;
   logic        d3_vld, d3_rdy, d3_full, d3_empty;
   logic [2:0]  d4_el;
   logic [1:0]  d3_el;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] q4[$];
   logic [31:0] q3[$];

   always #5 clk = ~clk;

   spi_slave_obi_tx_fifo #(.DATA_WIDTH(32), .DEPTH(4)) u_dut4 (
      .obi_aclk(clk), .obi_aresetn(rst_n), .flush_i(flush),
      .data_i(din), .valid_i(vld), .ready_o(d4_rdy),
      .data_o(d4_dat), .valid_o(d4_vld), .ready_i(rdy),
      .elements_o(d4_el), .full_o(d4_full), .empty_o(d4_empty));

   spi_slave_obi_tx_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
      .obi_aclk(clk), .obi_aresetn(rst_n), .flush_i(flush),
      .data_i(din), .valid_i(vld), .ready_o(d3_rdy),
      .data_o(d3_dat), .valid_o(d3_vld), .ready_i(rdy),
      .elements_o(d3_el), .full_o(d3_full), .empty_o(d3_empty));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: the outputs are checked at the falling edge, against the model queues.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("d4_elements", 32'(d4_el), 32'(q4.size()));
         chk("d4_ready", 32'(d4_rdy), 32'(q4.size() < 4 && !flush));
         chk("d4_valid", 32'(d4_vld), 32'(q4.size() != 0));
         chk("d4_full", 32'(d4_full), 32'(q4.size() == 4));
         chk("d4_empty", 32'(d4_empty), 32'(q4.size() == 0));
         if (q4.size() != 0) chk("d4_data", d4_dat, q4[0]);
         if (q4.size() != 0 && rdy && !flush) void'(q4.pop_front());

         chk("d3_elements", 32'(d3_el), 32'(q3.size()));
         chk("d3_ready", 32'(d3_rdy), 32'(q3.size() < 3 && !flush));
         chk("d3_valid", 32'(d3_vld), 32'(q3.size() != 0));
         chk("d3_full", 32'(d3_full), 32'(q3.size() == 3));
         chk("d3_empty", 32'(d3_empty), 32'(q3.size() == 0));
         if (q3.size() != 0) chk("d3_data", d3_dat, q3[0]);
         if (q3.size() != 0 && rdy && !flush) void'(q3.pop_front());
      end
   end

   // Stimulus: drive one cycle, and push the expected word if the model says the word is accepted.
   task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
      logic a4, a3;
      vld = v; din = d; rdy = r; flush = f;
      a4 = v && !f && (q4.size() < 4);
      a3 = v && !f && (q3.size() < 3);
      @(posedge clk);
      if (f) begin
         q4.delete();
         q3.delete();
      end else begin
         if (a4) q4.push_back(d);
         if (a3) q3.push_back(d);
      end
      #1;
   endtask

   task automatic drain();
      int guard = 0;
      while ((q4.size() != 0 || q3.size() != 0) && guard < 20) begin
         cyc(1'b0, 32'h0, 1'b1, 1'b0);
         guard++;
      end
      chk("drain_done", 32'(q4.size() + q3.size()), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_d4_valid"}, 32'(d4_vld), 32'd0);
      chk({tag, "_d4_ready"}, 32'(d4_rdy), 32'd1);
      chk({tag, "_d4_empty"}, 32'(d4_empty), 32'd1);
      chk({tag, "_d4_full"}, 32'(d4_full), 32'd0);
      chk({tag, "_d4_elements"}, 32'(d4_el), 32'd0);
      chk({tag, "_d4_data"}, d4_dat, 32'd0);
      chk({tag, "_d3_valid"}, 32'(d3_vld), 32'd0);
      chk({tag, "_d3_elements"}, 32'(d3_el), 32'd0);
      chk({tag, "_d3_data"}, d3_dat, 32'd0);
   endtask

   initial begin
      int w;
      int budget;
      logic v, r, a3;

      // Reset, then idle.
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("rst_hold");
      rst_n = 1'b1;
      #1;
      chk_reset_outputs("rst_release");
      cyc(1'b0, 32'h0, 1'b0, 1'b0);

      // Fill to full with the sink stalled, attempt an extra push, then drain in order.
      for (int i = 1; i <= 4; i++) cyc(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      chk("fill_full", 32'(d4_full), 32'd1);
      cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      chk("fill_elements", 32'(d4_el), 32'd4);
      drain();

      // Wrap-around on the DEPTH-3 instance with valid and ready toggled.
      w = 1;
      budget = 0;
      while (w <= 10 && budget < 200) begin
         v = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         a3 = v && (q3.size() < 3);
         cyc(v, 32'(w), r, 1'b0);
         if (a3) w++;
         budget++;
      end
      chk("wrap_budget", 32'(w), 32'd11);
      drain();

      // Simultaneous push and pop when one word is stored: there must be no bubble.
      cyc(1'b1, 32'h11, 1'b0, 1'b0);
      cyc(1'b1, 32'h22, 1'b1, 1'b0);
      chk("pp1_data", d4_dat, 32'h22);
      chk("pp1_elements", 32'(d4_el), 32'd1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      // At full, a pop still happens, but the push is refused.
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h33 + 32'(i), 1'b0, 1'b0);
      cyc(1'b1, 32'h66, 1'b1, 1'b0);
      chk("ppfull_elements", 32'(d4_el), 32'd3);
      drain();

      // Flush in the middle of the stream, with a push and a pop in the same cycle.
      cyc(1'b1, 32'h55, 1'b0, 1'b0);
      cyc(1'b1, 32'h66, 1'b0, 1'b0);
      cyc(1'b1, 32'h77, 1'b0, 1'b0);
      cyc(1'b1, 32'h88, 1'b1, 1'b1);
      chk("flush_elements", 32'(d4_el), 32'd0);
      chk("flush_empty", 32'(d4_empty), 32'd1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      cyc(1'b1, 32'h99, 1'b0, 1'b0);
      chk("flush_next", d4_dat, 32'h99);
      drain();

      // Asynchronous reset between clock edges.
      cyc(1'b1, 32'hC1, 1'b0, 1'b0);
      cyc(1'b1, 32'hC2, 1'b0, 1'b0);
      vld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("arst");
      q4.delete();
      q3.delete();
      #2 rst_n = 1'b1;
      cyc(1'b1, 32'h1234, 1'b0, 1'b0);
      chk("arst_first", d4_dat, 32'h1234);
      chk("arst_first_vld", 32'(d4_vld), 32'd1);
      drain();

      repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
